multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 58 +++++
 rtl/multicycle_control.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_if
// Description : Control/status bundle between the multicycle controller and
//               the datapath/memory. trap_o exists only when ILLEGAL_TRAP_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_if #(
    parameter int ALU_OP_W = 3
);
    logic [5:0]          opcode_i;
    logic                mem_ready_i;
    logic                mem_req_o;
    logic                mem_write_o;
    logic                i_or_d_o;
    logic                ir_write_o;
    logic                pc_write_o;
    logic                pc_write_eq_o;
    logic                pc_write_ne_o;
    logic [1:0]          pc_source_o;
    logic                reg_write_o;
    logic                reg_dst_o;
    logic                mem_to_reg_o;
    logic                alu_src_a_o;
    logic [1:0]          alu_src_b_o;
    logic [ALU_OP_W-1:0] alu_op_o;
    logic [3:0]          state_o;
    logic                err_o;
`ifdef ILLEGAL_TRAP_EN
    logic                trap_o;
`endif

    // Controller side
    modport master (
        input  opcode_i, mem_ready_i,
`ifdef ILLEGAL_TRAP_EN
        output trap_o,
`endif
        output mem_req_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o,
               pc_write_eq_o, pc_write_ne_o, pc_source_o, reg_write_o,
               reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o,
               state_o, err_o
    );

    // Datapath/memory side
    modport slave (
        output opcode_i, mem_ready_i,
`ifdef ILLEGAL_TRAP_EN
        input  trap_o,
`endif
        input  mem_req_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o,
               pc_write_eq_o, pc_write_ne_o, pc_source_o, reg_write_o,
               reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o,
               state_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle MIPS-style control FSM with memory wait timeout.
//               Optional macro ILLEGAL_TRAP_EN: illegal opcodes park the FSM
//               in TRAP with a sticky trap_o instead of acting as a NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int ALU_OP_W = 3,
    parameter int TIMEOUT  = 16
) (
    input  wire logic            clk,
    input  wire logic            reset,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE = 4'd1,  S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,  S_MEM_WB = 4'd4,  S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,  S_WB_R   = 4'd7,  S_EXEC_I   = 4'd8,
        S_WB_I     = 4'd9,  S_BRANCH = 4'd10, S_JUMP     = 4'd11,
        S_TRAP     = 4'd14, S_ERROR  = 4'd15
    } state_t;

    localparam logic [2:0] c_ALU_ADD = 3'd0, c_ALU_AND = 3'd1, c_ALU_SUB = 3'd2,
                           c_ALU_OR  = 3'd5, c_ALU_LUI = 3'd6, c_ALU_FUNCT = 3'd7;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_WAIT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

`ifdef ILLEGAL_TRAP_EN
    localparam state_t c_ILLEGAL_DST = S_TRAP;
`else
    localparam state_t c_ILLEGAL_DST = S_FETCH;
`endif

    // Moore part of the control word, registered alongside the state
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       i_or_d;
        logic       pc_write;
        logic       pc_write_eq;
        logic       pc_write_ne;
        logic [1:0] pc_source;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
    } ctrl_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt;
    logic [5:0]       r_opcode;
    logic [5:0]       w_opcode;
    ctrl_t            r_ctrl;
    logic             r_err;
    logic             w_fetch_ack;
`ifdef ILLEGAL_TRAP_EN
    logic             r_trap;
`endif

    // Control word for a state; opc is the opcode latched for that state
    function automatic ctrl_t f_ctrl(input state_t s, input logic [5:0] opc);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = 2'd1; c.alu_op = c_ALU_ADD; end
            S_DECODE:   begin c.alu_src_b = 2'd3; c.alu_op = c_ALU_ADD; end
            S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = c_ALU_ADD; end
            S_MEM_RD:   begin c.mem_req = 1'b1; c.i_or_d = 1'b1; end
            S_MEM_WR:   begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            S_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd0; c.alu_op = c_ALU_FUNCT; end
            S_WB_R:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
                case (opc)
                    6'h0C:   c.alu_op = c_ALU_AND;
                    6'h0D:   c.alu_op = c_ALU_OR;
                    6'h0F:   c.alu_op = c_ALU_LUI;
                    default: c.alu_op = c_ALU_ADD;
                endcase
            end
            S_WB_I:     c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_op      = c_ALU_SUB;
                c.pc_source   = 2'd1;
                c.pc_write_eq = (opc == 6'h04);
                c.pc_write_ne = (opc == 6'h05);
            end
            S_JUMP:     begin c.pc_write = 1'b1; c.pc_source = 2'd2; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    // Next state, wait counter and opcode latch
    always_comb begin
        w_next     = r_state;
        w_wait_cnt = '0;
        w_opcode   = r_opcode;
        case (r_state)
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                if (bus.mem_ready_i) begin
                    if (r_state == S_FETCH)       w_next = S_DECODE;
                    else if (r_state == S_MEM_RD) w_next = S_MEM_WB;
                    else                          w_next = S_FETCH;
                end else if ((TIMEOUT > 0) && (r_wait_cnt == c_WAIT_LAST)) begin
                    w_next = S_ERROR;
                end else begin
                    w_wait_cnt = r_wait_cnt + 1'b1;
                end
            end
            S_DECODE: begin
                w_opcode = bus.opcode_i;
                case (bus.opcode_i)
                    6'h00:                      w_next = S_EXEC_R;
                    6'h08, 6'h0C, 6'h0D, 6'h0F: w_next = S_EXEC_I;
                    6'h23, 6'h2B:               w_next = S_MEM_ADDR;
                    6'h04, 6'h05:               w_next = S_BRANCH;
                    6'h02:                      w_next = S_JUMP;
                    default:                    w_next = c_ILLEGAL_DST;
                endcase
            end
            S_MEM_ADDR: w_next = (r_opcode == 6'h2B) ? S_MEM_WR : S_MEM_RD;
            S_EXEC_R:   w_next = S_WB_R;
            S_EXEC_I:   w_next = S_WB_I;
            S_MEM_WB, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            S_ERROR:    w_next = S_ERROR;
            default:    w_next = S_FETCH;
        endcase
    end

    // State, counters, sticky flags and registered control word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_opcode   <= '0;
            r_ctrl     <= f_ctrl(S_FETCH, 6'd0);
            r_err      <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            r_trap     <= 1'b0;
`endif
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_cnt;
            r_opcode   <= w_opcode;
            r_ctrl     <= f_ctrl(w_next, w_opcode);
            r_err      <= r_err | (w_next == S_ERROR);
`ifdef ILLEGAL_TRAP_EN
            r_trap     <= r_trap | (w_next == S_TRAP);
`endif
        end
    end

    // Fetch completion strobes are Mealy on mem_ready_i; gated so reset holds them low
    assign w_fetch_ack = (r_state == S_FETCH) && bus.mem_ready_i && reset;

    assign bus.mem_req_o     = r_ctrl.mem_req;
    assign bus.mem_write_o   = r_ctrl.mem_write;
    assign bus.i_or_d_o      = r_ctrl.i_or_d;
    assign bus.ir_write_o    = w_fetch_ack;
    assign bus.pc_write_o    = r_ctrl.pc_write | w_fetch_ack;
    assign bus.pc_write_eq_o = r_ctrl.pc_write_eq;
    assign bus.pc_write_ne_o = r_ctrl.pc_write_ne;
    assign bus.pc_source_o   = r_ctrl.pc_source;
    assign bus.reg_write_o   = r_ctrl.reg_write;
    assign bus.reg_dst_o     = r_ctrl.reg_dst;
    assign bus.mem_to_reg_o  = r_ctrl.mem_to_reg;
    assign bus.alu_src_a_o   = r_ctrl.alu_src_a;
    assign bus.alu_src_b_o   = r_ctrl.alu_src_b;
    assign bus.alu_op_o      = ALU_OP_W'(r_ctrl.alu_op);
    assign bus.state_o       = r_state;
    assign bus.err_o         = r_err;
`ifdef ILLEGAL_TRAP_EN
    assign bus.trap_o        = r_trap;
`endif
endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Scoreboard bench for multicycle_control: per-instruction
//               cycle plans from a behavioural model, monitor compares every
//               cycle. Also exercises ILLEGAL_TRAP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;
    localparam int c_ALU_OP_W = 5;
    localparam int c_TIMEOUT  = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if #(.ALU_OP_W(c_ALU_OP_W)) bus ();
    multicycle_control_if #(.ALU_OP_W(c_ALU_OP_W)) bus_nt ();

    multicycle_control #(.ALU_OP_W(c_ALU_OP_W), .TIMEOUT(c_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    multicycle_control #(.ALU_OP_W(c_ALU_OP_W), .TIMEOUT(0)) dut_nt (
        .clk(clk), .reset(reset), .bus(bus_nt)
    );

    typedef struct packed {
        logic [3:0] state;
        logic       mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_eq, pc_write_ne;
        logic [1:0] pc_source;
        logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b;
        logic [4:0] alu_op;
        logic       err, trap;
    } obs_t;

    typedef struct {
        logic [5:0] opc;
        logic       rdy;
        obs_t       e;
    } cyc_t;

    cyc_t plan[$];
    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   sb_active = 1'b0;
    logic [5:0] legal_ops [10] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
    logic [5:0] bad_ops   [3]  = '{6'h3F, 6'h01, 6'h2A};

    // Expected outputs of a state for an instruction with opcode op
    function automatic obs_t exp_out(int st, logic [5:0] op, logic rdy);
        obs_t e;
        e = '0;
        e.state = 4'(st);
        case (st)
            0:  begin e.mem_req = 1; e.alu_src_b = 1; e.ir_write = rdy; e.pc_write = rdy; end
            1:  e.alu_src_b = 3;
            2:  begin e.alu_src_a = 1; e.alu_src_b = 2; end
            3:  begin e.mem_req = 1; e.i_or_d = 1; end
            4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
            5:  begin e.mem_req = 1; e.mem_write = 1; e.i_or_d = 1; end
            6:  begin e.alu_src_a = 1; e.alu_op = 7; end
            7:  begin e.reg_write = 1; e.reg_dst = 1; end
            8: begin
                e.alu_src_a = 1; e.alu_src_b = 2;
                e.alu_op = (op == 6'h0C) ? 5'd1 : (op == 6'h0D) ? 5'd5 : (op == 6'h0F) ? 5'd6 : 5'd0;
            end
            9:  e.reg_write = 1;
            10: begin
                e.alu_src_a = 1; e.alu_op = 2; e.pc_source = 1;
                e.pc_write_eq = (op == 6'h04); e.pc_write_ne = (op == 6'h05);
            end
            11: begin e.pc_write = 1; e.pc_source = 2; end
            14: e.trap = 1;
            15: e.err = 1;
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s.state = bus.state_o;         s.mem_req = bus.mem_req_o;
        s.mem_write = bus.mem_write_o; s.i_or_d = bus.i_or_d_o;
        s.ir_write = bus.ir_write_o;   s.pc_write = bus.pc_write_o;
        s.pc_write_eq = bus.pc_write_eq_o; s.pc_write_ne = bus.pc_write_ne_o;
        s.pc_source = bus.pc_source_o; s.reg_write = bus.reg_write_o;
        s.reg_dst = bus.reg_dst_o;     s.mem_to_reg = bus.mem_to_reg_o;
        s.alu_src_a = bus.alu_src_a_o; s.alu_src_b = bus.alu_src_b_o;
        s.alu_op = bus.alu_op_o;       s.err = bus.err_o;
`ifdef ILLEGAL_TRAP_EN
        s.trap = bus.trap_o;
`else
        s.trap = 1'b0;
`endif
        return s;
    endfunction

    task automatic check(string name, obs_t act, obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: state %0d got %h, expected state %0d vector %h", name, act.state, act, exp.state, exp);
        end
    endtask

    task automatic check_val(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(logic [5:0] opc, logic rdy, int st, logic [5:0] op);
        cyc_t c;
        c.opc = opc; c.rdy = rdy; c.e = exp_out(st, op, rdy);
        plan.push_back(c);
    endtask

    // Cycle plan for one instruction: fetch waits wf, data memory waits wm
    task automatic build_instr(logic [5:0] op, int wf, int wm);
        for (int i = 0; i < wf; i++) add(6'($urandom), 1'b0, 0, op);
        add(6'($urandom), 1'b1, 0, op);
        add(op, 1'($urandom), 1, op);
        case (op)
            6'h00: begin add(6'($urandom), 1'($urandom), 6, op); add(6'($urandom), 1'($urandom), 7, op); end
            6'h08, 6'h0C, 6'h0D, 6'h0F: begin
                add(6'($urandom), 1'($urandom), 8, op); add(6'($urandom), 1'($urandom), 9, op);
            end
            6'h23: begin
                add(6'($urandom), 1'($urandom), 2, op);
                for (int i = 0; i < wm; i++) add(6'($urandom), 1'b0, 3, op);
                add(6'($urandom), 1'b1, 3, op);
                add(6'($urandom), 1'($urandom), 4, op);
            end
            6'h2B: begin
                add(6'($urandom), 1'($urandom), 2, op);
                for (int i = 0; i < wm; i++) add(6'($urandom), 1'b0, 5, op);
                add(6'($urandom), 1'b1, 5, op);
            end
            6'h04, 6'h05: add(6'($urandom), 1'($urandom), 10, op);
            6'h02:        add(6'($urandom), 1'($urandom), 11, op);
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int i = 0; i < 4; i++) add(6'($urandom), 1'($urandom), 14, op);
`endif
            end
        endcase
    endtask

    // Drive planned cycles, leaving 'keep' entries undriven, then discard the rest
    task automatic drive_plan(int keep);
        cyc_t c;
        while (plan.size() > keep) begin
            c = plan.pop_front();
            bus.opcode_i    = c.opc;
            bus.mem_ready_i = c.rdy;
            exp_q.push_back(c.e);
            @(posedge clk); #1;
        end
        plan.delete();
    endtask

    // Monitor: compare DUT outputs against the scoreboard each cycle
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (sb_active) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL sb_underflow: got DUT state %0d with no expected entry", bus.state_o);
                end else begin
                    e = exp_q.pop_front();
                    check("sb", sample(), e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op;
        bus.opcode_i = 6'h00; bus.mem_ready_i = 1'b0;
        bus_nt.opcode_i = 6'h00; bus_nt.mem_ready_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_values", sample(), exp_out(0, 6'h00, 1'b0));
        reset = 1'b1;

        // Directed instructions then random mix, all scoreboarded
        sb_active = 1'b1;
        build_instr(6'h23, 2, 2);
        build_instr(6'h05, 0, 0);
        build_instr(6'h04, 1, 0);
        build_instr(6'h0D, 1, 0);
        build_instr(6'h2B, 0, 1);
        build_instr(6'h08, 3, 3);
`ifndef ILLEGAL_TRAP_EN
        build_instr(6'h3F, 0, 0);
`endif
        for (int n = 0; n < 40; n++) begin
            op = legal_ops[$urandom_range(0, 9)];
`ifndef ILLEGAL_TRAP_EN
            if ($urandom_range(0, 5) == 0) op = bad_ops[$urandom_range(0, 2)];
`endif
            build_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        drive_plan(0);

        // Asynchronous reset in the middle of a store wait
        build_instr(6'h2B, 1, 3);
        drive_plan(2);
        sb_active = 1'b0;
        check_val("pre_reset_state", int'(bus.state_o), 5);
        bus.mem_ready_i = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", sample(), exp_out(0, 6'h00, 1'b0));
        @(posedge clk); #1;
        reset = 1'b1;

        // Fetch timeout: four wait cycles then sticky ERROR
        sb_active = 1'b1;
        for (int i = 0; i < c_TIMEOUT; i++) add(6'($urandom), 1'b0, 0, 6'h00);
        for (int i = 0; i < 6; i++) add(6'($urandom), 1'($urandom), 15, 6'h00);
        drive_plan(0);
        sb_active = 1'b0;
        bus.mem_ready_i = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        check("err_sticky", sample(), exp_out(15, 6'h00, 1'b0));
        check_val("nt_state", int'(bus_nt.state_o), 0);
        check_val("nt_err", int'(bus_nt.err_o), 0);
        check_val("nt_mem_req", int'(bus_nt.mem_req_o), 1);
        reset = 1'b0;
        #1;
        check("err_cleared", sample(), exp_out(0, 6'h00, 1'b0));
        @(posedge clk); #1;
        reset = 1'b1;

        // Normal operation after leaving ERROR; trap last since it is sticky
        sb_active = 1'b1;
        build_instr(6'h00, 0, 0);
        build_instr(6'h0F, 0, 0);
`ifdef ILLEGAL_TRAP_EN
        build_instr(6'h3F, 1, 0);
`else
        build_instr(6'h3F, 1, 0);
        build_instr(6'h02, 0, 0);
`endif
        drive_plan(0);
        sb_active = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
